// File: rtl/spi_pkg.sv
// Shared constants for the SPI target: register addresses, status bit positions
// and the default byte returned on MISO when nothing is queued.
package spi_pkg;

    localparam logic REG_CTL  = 1'b0;
    localparam logic REG_DATA = 1'b1;

    localparam int unsigned ST_RXFULL  = 0;
    localparam int unsigned ST_OVR     = 1;
    localparam int unsigned ST_TXEMPTY = 2;
    localparam int unsigned ST_IRQEN   = 4;
    localparam int unsigned ST_SEL     = 7;

    localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_sync.sv
// N-flop synchronizer for an asynchronous input, plus one history flop that
// yields single-cycle rise/fall pulses on the synchronized value.
module spi_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Shift the raw input through the synchronizer chain and keep one history bit.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_d};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign o_q    = sync_q[STAGES-1];
    assign o_rise = o_q & ~prev_q;
    assign o_fall = ~o_q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI target with a two-register CPU interface (status/ctl, data) and a
// level interrupt. All SPI pins are oversampled in the i_clk domain.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = IDLE_BYTE_DEFAULT
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_addr,
    input  logic       i_cs,
    input  logic       i_we,
    input  logic [7:0] i_dat,
    output logic [7:0] o_dat,
    input  logic       i_sck,
    input  logic       i_ss_n,
    input  logic       i_mosi,
    output logic       o_miso,
    output logic       o_miso_oe,
    output logic       o_irq
);

    logic sck_s, sck_rise, sck_fall;
    logic ss_s, ss_rise, ss_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    // SS_n resets to the deselected level so reset never fakes a select edge.
    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_sck),
        .o_q     (sck_s),
        .o_rise  (sck_rise),
        .o_fall  (sck_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_ss_n),
        .o_q     (ss_s),
        .o_rise  (ss_rise),
        .o_fall  (ss_fall)
    );

    spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_mosi),
        .o_q     (mosi_s),
        .o_rise  (mosi_rise),
        .o_fall  (mosi_fall)
    );

    assign unused_sync = mosi_rise ^ mosi_fall ^ sck_s;

    logic       selected;
    logic       rd_strobe, wr_ctl, wr_data;
    logic       reload, byte_done;
    logic [7:0] rx_byte;
    logic [7:0] status;

    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       rx_bit_q, rx_bit_d;
    logic       rx_full_q, rx_full_d;
    logic       overrun_q, overrun_d;
    logic       tx_full_q, tx_full_d;
    logic       irq_en_q, irq_en_d;
    logic       irq_q, irq_d;

    assign selected  = ~ss_s;
    assign rd_strobe = i_cs & ~i_we & (i_addr == REG_DATA);
    assign wr_ctl    = i_cs & i_we & (i_addr == REG_CTL);
    assign wr_data   = i_cs & i_we & (i_addr == REG_DATA);

    // Next-state: SPI shifting, byte completion, and CPU register side effects.
    always_comb begin
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        tx_hold_d = tx_hold_q;
        bit_cnt_d = bit_cnt_q;
        rx_bit_d  = rx_bit_q;
        rx_full_d = rx_full_q;
        overrun_d = overrun_q;
        tx_full_d = tx_full_q;
        irq_en_d  = irq_en_q;
        reload    = 1'b0;
        byte_done = 1'b0;
        // The LSB is held in rx_bit_q until the fall so shift[0] can still be
        // driven out on the 8th bit; the final MOSI bit is taken directly.
        rx_byte   = {shift_q[6:0], mosi_s};

        if (ss_fall) begin
            reload    = 1'b1;
            bit_cnt_d = 3'd0;
        end else if (ss_rise) begin
            bit_cnt_d = 3'd0;
        end else if (selected) begin
            if (sck_rise) begin
                rx_bit_d = mosi_s;
                if (bit_cnt_q == 3'd7) begin
                    byte_done = 1'b1;
                    reload    = 1'b1;
                    bit_cnt_d = 3'd0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end else if (sck_fall && bit_cnt_q != 3'd0) begin
                // bit_cnt == 0 here is the fall after a reload: keep the new byte.
                shift_d = {shift_q[6:0], rx_bit_q};
            end
        end

        if (reload) begin
            shift_d   = tx_full_q ? tx_hold_q : IDLE_BYTE;
            tx_full_d = 1'b0;
        end

        if (rd_strobe) begin
            rx_full_d = 1'b0;
        end
        if (wr_ctl) begin
            irq_en_d = i_dat[ST_IRQEN];
            if (i_dat[ST_OVR]) begin
                overrun_d = 1'b0;
            end
        end

        if (byte_done) begin
            if (rx_full_q && !rd_strobe) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d = rx_byte;
                rx_full_d = 1'b1;
            end
        end

        if (wr_data) begin
            tx_hold_d = i_dat;
            tx_full_d = 1'b1;
        end

        irq_d = irq_en_q & (rx_full_q | overrun_q);
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_q   <= IDLE_BYTE;
            rx_data_q <= 8'h00;
            tx_hold_q <= 8'h00;
            bit_cnt_q <= 3'd0;
            rx_bit_q  <= 1'b0;
            rx_full_q <= 1'b0;
            overrun_q <= 1'b0;
            tx_full_q <= 1'b0;
            irq_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            tx_hold_q <= tx_hold_d;
            bit_cnt_q <= bit_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_full_q <= rx_full_d;
            overrun_q <= overrun_d;
            tx_full_q <= tx_full_d;
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
        end
    end

    // Status word and read-data mux.
    always_comb begin
        status             = 8'h00;
        status[ST_RXFULL]  = rx_full_q;
        status[ST_OVR]     = overrun_q;
        status[ST_TXEMPTY] = ~tx_full_q;
        status[ST_IRQEN]   = irq_en_q;
        status[ST_SEL]     = selected;
        o_dat              = (i_addr == REG_DATA) ? rx_data_q : status;
    end

    assign o_miso    = selected & shift_q[7];
    assign o_miso_oe = selected;
    assign o_irq     = irq_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a table of single-byte transfers plus
// hand-written sequences for overrun, abort, read/complete collision and reset.
module tb_spi_slave;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_addr = 1'b0;
    logic       i_cs = 1'b0;
    logic       i_we = 1'b0;
    logic [7:0] i_dat = 8'h00;
    logic [7:0] o_dat;
    logic       i_sck = 1'b0;
    logic       i_ss_n = 1'b1;
    logic       i_mosi = 1'b0;
    logic       o_miso;
    logic       o_miso_oe;
    logic       o_irq;

    int n_chk = 0;
    int n_err = 0;

    spi_slave dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_addr    (i_addr),
        .i_cs      (i_cs),
        .i_we      (i_we),
        .i_dat     (i_dat),
        .o_dat     (o_dat),
        .i_sck     (i_sck),
        .i_ss_n    (i_ss_n),
        .i_mosi    (i_mosi),
        .o_miso    (o_miso),
        .o_miso_oe (o_miso_oe),
        .o_irq     (o_irq)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic       has_tx;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_status;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Look at a register without a bus strobe (o_dat is combinational).
    task automatic peek(input logic addr, output logic [7:0] val);
        i_addr = addr;
        #1;
        val = o_dat;
    endtask

    task automatic bus_write(input logic addr, input logic [7:0] dat);
        @(negedge i_clk);
        i_cs = 1'b1; i_we = 1'b1; i_addr = addr; i_dat = dat;
        @(negedge i_clk);
        i_cs = 1'b0; i_we = 1'b0;
    endtask

    task automatic bus_read(output logic [7:0] val);
        @(negedge i_clk);
        i_cs = 1'b1; i_we = 1'b0; i_addr = 1'b1;
        #1;
        val = o_dat;
        @(negedge i_clk);
        i_cs = 1'b0;
    endtask

    task automatic select();
        @(negedge i_clk);
        i_ss_n = 1'b0;
        repeat (4) @(negedge i_clk);
    endtask

    task automatic deselect();
        @(negedge i_clk);
        i_ss_n = 1'b1;
        repeat (4) @(negedge i_clk);
    endtask

    // Master side, SCK phases of 4 i_clk. mode 1: check rx_full latency on the
    // last rise; mode 2: issue a data read strobe in the byte-complete cycle.
    task automatic spi_xfer(input logic [7:0] mosi, input int nbits, input int mode,
                            input logic [7:0] exp_rd, output logic [7:0] miso);
        logic [7:0] v;
        miso = 8'h00;
        for (int i = 7; i >= 8 - nbits; i--) begin
            @(negedge i_clk);
            i_mosi = mosi[i];
            repeat (3) @(negedge i_clk);
            miso[i] = o_miso;
            i_sck = 1'b1;
            if (i == 0 && mode == 1) begin
                repeat (2) @(negedge i_clk);
                peek(1'b0, v);
                check("rxfull_lat_early", {7'd0, v[0]}, 8'd0);
                @(negedge i_clk);
                peek(1'b0, v);
                check("rxfull_lat_on_time", {7'd0, v[0]}, 8'd1);
                @(negedge i_clk);
            end else if (i == 0 && mode == 2) begin
                repeat (2) @(negedge i_clk);
                i_cs = 1'b1; i_we = 1'b0; i_addr = 1'b1;
                #1;
                check("collide_read_data", o_dat, exp_rd);
                @(negedge i_clk);
                i_cs = 1'b0;
                @(negedge i_clk);
            end else begin
                repeat (4) @(negedge i_clk);
            end
            i_sck = 1'b0;
        end
        repeat (4) @(negedge i_clk);
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] m;
        logic [7:0] m2;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h95, 8'h3C};
        vecs[1] = '{1'b0, 8'h00, 8'h5A, 8'hFF, 8'h95, 8'h5A};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'h95, 8'hFF};
        vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h95, 8'h7E};

        // Reset state
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        peek(1'b0, v);
        check("reset_status", v, 8'h04);
        peek(1'b1, v);
        check("reset_rxdata", v, 8'h00);
        check("reset_irq", {7'd0, o_irq}, 8'd0);
        check("reset_oe", {7'd0, o_miso_oe}, 8'd0);
        check("reset_miso", {7'd0, o_miso}, 8'd0);

        bus_write(1'b0, 8'h10);
        peek(1'b0, v);
        check("irqen_status", v, 8'h14);

        // Table of single-byte transfers
        for (int k = 0; k < 4; k++) begin
            if (vecs[k].has_tx) bus_write(1'b1, vecs[k].tx);
            select();
            check("vec_oe", {7'd0, o_miso_oe}, 8'd1);
            spi_xfer(vecs[k].mosi, 8, 1, 8'h00, m);
            check("vec_miso", m, vecs[k].exp_miso);
            peek(1'b0, v);
            check("vec_status", v, vecs[k].exp_status);
            check("vec_irq_set", {7'd0, o_irq}, 8'd1);
            bus_read(v);
            check("vec_rxdata", v, vecs[k].exp_rx);
            check("vec_irq_lag", {7'd0, o_irq}, 8'd1);
            peek(1'b0, v);
            check("vec_status_read", v, 8'h94);
            @(negedge i_clk);
            check("vec_irq_clear", {7'd0, o_irq}, 8'd0);
            deselect();
            peek(1'b0, v);
            check("vec_status_idle", v, 8'h14);
            check("vec_oe_off", {7'd0, o_miso_oe}, 8'd0);
        end

        // Overrun: two bytes without reading
        select();
        spi_xfer(8'h11, 8, 0, 8'h00, m);
        spi_xfer(8'h22, 8, 0, 8'h00, m2);
        check("ovr_miso1", m, 8'hFF);
        check("ovr_miso2", m2, 8'hFF);
        peek(1'b0, v);
        check("ovr_status", v, 8'h97);
        peek(1'b1, v);
        check("ovr_rxdata_kept", v, 8'h11);
        bus_write(1'b0, 8'h12);
        peek(1'b0, v);
        check("ovr_w1c_status", v, 8'h95);
        bus_read(v);
        check("ovr_read", v, 8'h11);
        deselect();

        // Abort after 5 rises; TX byte queued after select stays queued
        select();
        bus_write(1'b1, 8'hC3);
        peek(1'b0, v);
        check("abort_queued", v, 8'h90);
        spi_xfer(8'hFF, 5, 0, 8'h00, m);
        deselect();
        peek(1'b0, v);
        check("abort_status", v, 8'h10);
        select();
        peek(1'b0, v);
        check("abort_loaded", v, 8'h94);
        spi_xfer(8'h81, 8, 0, 8'h00, m);
        check("abort_next_miso", m, 8'hC3);
        peek(1'b0, v);
        check("abort_next_status", v, 8'h95);
        bus_read(v);
        check("abort_next_rx", v, 8'h81);
        deselect();

        // Read strobe in the same cycle as the second byte completing
        select();
        spi_xfer(8'h5A, 8, 0, 8'h00, m);
        spi_xfer(8'hA6, 8, 2, 8'h5A, m);
        peek(1'b0, v);
        check("collide_status", v, 8'h95);
        peek(1'b1, v);
        check("collide_rxdata", v, 8'hA6);
        bus_read(v);
        check("collide_read2", v, 8'hA6);
        deselect();

        // Reset in the middle of a byte
        select();
        spi_xfer(8'h33, 8, 0, 8'h00, m);
        spi_xfer(8'hF0, 3, 0, 8'h00, m);
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        peek(1'b0, v);
        check("midreset_status", v, 8'h04);
        check("midreset_miso", {7'd0, o_miso}, 8'd0);
        check("midreset_oe", {7'd0, o_miso_oe}, 8'd0);
        check("midreset_irq", {7'd0, o_irq}, 8'd0);
        repeat (4) @(negedge i_clk);
        deselect();
        bus_write(1'b0, 8'h10);
        bus_write(1'b1, 8'h99);
        select();
        spi_xfer(8'h42, 8, 0, 8'h00, m);
        check("postreset_miso", m, 8'h99);
        peek(1'b0, v);
        check("postreset_status", v, 8'h95);
        bus_read(v);
        check("postreset_rx", v, 8'h42);
        deselect();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
